// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcodes, FSM state encoding, reserved-op result.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOTA = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  // Fill bit for Y/Y_HI on reserved opcodes (and Y_HI on all single-cycle ops).
  localparam logic RSV_FILL = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned unit: radix-2 shift-add multiplier and restoring divider.
// One iteration per cycle; done rises after WIDTH iterations and lasts one cycle.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             active;
  logic             is_div;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign add_w   = {1'b0, hi_q} + {1'b0, opnd};
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd};
  assign done    = active && (cnt == '0);
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Multiply: lo holds the multiplier, shifted out as the product fills in.
  // Divide: lo holds the dividend, shifted out as quotient bits fill in; B=0
  // naturally yields an all-ones quotient with the dividend as remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
      is_div <= 1'b0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (start) begin
      cnt    <= CW'(WIDTH);
      active <= 1'b1;
      is_div <= op_div;
      opnd   <= op_div ? b : a;
      hi_q   <= '0;
      lo_q   <= op_div ? a : b;
    end else if (active) begin
      if (cnt == '0) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        if (is_div) begin
          if (!diff[WIDTH]) begin
            hi_q <= diff[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= shifted[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
        end else if (lo_q[0]) begin
          {hi_q, lo_q} <= {add_w, lo_q[WIDTH-1:1]};
        end else begin
          {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered result; MULU/DIVU via iterative unit when
// SEQ_ALU_MULDIV_EN is defined, otherwise they behave as reserved opcodes.
// state | meaning:  IDLE accept request | BUSY mul/div iterating | DONE result held
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_HI,
  output logic             Zero,
  output logic             overflow
);
  import seq_alu_pkg::*;

  localparam int M = WIDTH - 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] y_q, y_hi_q, alu_y, sum_w, diff_w;
  logic             ovf_q, alu_ovf;
  logic             load_alu, load_md, is_multi;
  logic             md_done;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic [SHW-1:0]   shamt;

  assign shamt = B[SHW-1:0];
  assign sum_w  = A + B;
  assign diff_w = A - B;

`ifdef SEQ_ALU_MULDIV_EN
  logic md_start;
  assign is_multi = (OP == OP_MULU) || (OP == OP_DIVU);
  assign md_start = in_valid && (state == S_IDLE) && is_multi;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .op_div (OP == OP_DIVU),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .hi     (md_hi),
    .lo     (md_lo)
  );
`else
  assign is_multi = 1'b0;
  assign md_done  = 1'b0;
  assign md_hi    = '0;
  assign md_lo    = '0;
`endif

  always_comb begin
    alu_y   = {WIDTH{RSV_FILL}};
    alu_ovf = 1'b0;
    case (OP)
      OP_AND:  alu_y = A & B;
      OP_OR:   alu_y = A | B;
      OP_ADD: begin
        alu_y   = sum_w;
        alu_ovf = (A[M] == B[M]) && (sum_w[M] != A[M]);
      end
      OP_XOR:  alu_y = A ^ B;
      OP_NOTA: alu_y = ~A;
      OP_NOR:  alu_y = ~(A | B);
      OP_SUB: begin
        alu_y   = diff_w;
        alu_ovf = (A[M] != B[M]) && (diff_w[M] != A[M]);
      end
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL:  alu_y = A << shamt;
      OP_SRL:  alu_y = A >> shamt;
      OP_SRA:  alu_y = $signed(A) >>> shamt;
      default: alu_y = {WIDTH{RSV_FILL}};
    endcase
  end

  always_comb begin
    state_n  = state;
    load_alu = 1'b0;
    load_md  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (is_multi) begin
            state_n = S_BUSY;
          end else begin
            state_n  = S_DONE;
            load_alu = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (md_done) begin
          state_n = S_DONE;
          load_md = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      y_q    <= '0;
      y_hi_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (load_alu) begin
        y_q    <= alu_y;
        y_hi_q <= {WIDTH{RSV_FILL}};
        ovf_q  <= alu_ovf;
      end else if (load_md) begin
        y_q    <= md_lo;
        y_hi_q <= md_hi;
        ovf_q  <= 1'b0;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign Y         = y_q;
  assign Y_HI      = y_hi_q;
  assign Zero      = (y_q == '0);
  assign overflow  = ovf_q;

endmodule
